// File: rtl/sent_frame_tx.sv
// SENT (SAE J2716) frame transmitter: sync, status, data nibbles, CRC and
// optional pause pulse, with a handshake to an external CRC calculator.
module sent_frame_tx #(
    parameter int TICK_W  = 16,
    parameter int CRC_TMO = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TICK_W-1:0] sent_tick_div,
    input  logic              sent_frame_req,
    output logic              sent_frame_ready,
    input  logic [2:0]        sent_frame_len,
    input  logic [23:0]       sent_frame_data,
    input  logic [3:0]        sent_status,
    input  logic              sent_pause_en,
    input  logic [9:0]        sent_pause_ticks,
    output logic              sent_crc_req,
    output logic [2:0]        sent_crc_len,
    output logic [23:0]       sent_crc_data,
    input  logic              sent_crc_ack,
    input  logic [3:0]        sent_crc,
    output logic              sent_out,
    output logic              sent_frame_done,
    output logic              sent_frame_err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CRC_REQ  = 3'd1;
    localparam logic [2:0] S_CRC_WAIT = 3'd2;
    localparam logic [2:0] S_SYNC     = 3'd3;
    localparam logic [2:0] S_STATUS   = 3'd4;
    localparam logic [2:0] S_DATA     = 3'd5;
    localparam logic [2:0] S_CRC      = 3'd6;
    localparam logic [2:0] S_PAUSE    = 3'd7;

    localparam int TMO_W = $clog2(CRC_TMO + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CRC_TMO - 1);

    logic [2:0]        r_state;
    logic [TICK_W-1:0] r_div;
    logic [TICK_W-1:0] r_pre;
    logic [9:0]        r_tick;
    logic [TMO_W-1:0]  r_tmo;
    logic [2:0]        r_len;
    logic [2:0]        r_nib;
    logic [23:0]       r_shift;
    logic [3:0]        r_status;
    logic [3:0]        r_crc;
    logic              r_pause_en;
    logic [9:0]        r_pause;
    logic              r_out;
    logic              r_ready;
    logic              r_done;
    logic              r_err;
    logic              r_crc_req;
    logic [2:0]        r_crc_len;
    logic [23:0]       r_crc_data;

    logic              w_accept;
    logic [2:0]        w_len_c;
    logic [9:0]        w_pause_c;
    logic              w_pulse;
    logic              w_nxt_pulse;
    logic [9:0]        w_plen;
    logic              w_tick_end;
    logic              w_last;
    logic              w_tmo;
    logic              w_last_nib;
    logic [2:0]        w_nxt;
    logic [TICK_W-1:0] w_nxt_pre;
    logic [9:0]        w_nxt_tick;

    assign w_accept  = sent_frame_req && r_ready;
    assign w_len_c   = (sent_frame_len == 3'd0) ? 3'd1 :
                       (sent_frame_len == 3'd7) ? 3'd6 : sent_frame_len;
    assign w_pause_c = (sent_pause_ticks < 10'd12) ? 10'd12 : sent_pause_ticks;

    // Line-pulse states are encoded contiguously from S_SYNC upward.
    assign w_pulse     = (r_state >= S_SYNC);
    assign w_nxt_pulse = (w_nxt >= S_SYNC);

    always_comb begin
        w_plen = 10'd56;
        case (r_state)
            S_STATUS: w_plen = 10'd12 + {6'd0, r_status};
            S_DATA:   w_plen = 10'd12 + {6'd0, r_shift[23:20]};
            S_CRC:    w_plen = 10'd12 + {6'd0, r_crc};
            S_PAUSE:  w_plen = r_pause;
            default:  w_plen = 10'd56;
        endcase
    end

    assign w_tick_end = (r_pre == r_div);
    assign w_last     = w_pulse && w_tick_end && (r_tick == w_plen - 10'd1);
    assign w_tmo      = (r_state == S_CRC_WAIT) && !sent_crc_ack &&
                        (r_tmo == TMO_LAST);
    assign w_last_nib = (r_nib == r_len - 3'd1);

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_accept) w_nxt = S_CRC_REQ;
            S_CRC_REQ:  w_nxt = S_CRC_WAIT;
            S_CRC_WAIT: begin
                if (sent_crc_ack)   w_nxt = S_SYNC;
                else if (w_tmo)     w_nxt = S_IDLE;
            end
            S_SYNC:     if (w_last) w_nxt = S_STATUS;
            S_STATUS:   if (w_last) w_nxt = S_DATA;
            S_DATA:     if (w_last && w_last_nib) w_nxt = S_CRC;
            S_CRC:      if (w_last) w_nxt = r_pause_en ? S_PAUSE : S_IDLE;
            S_PAUSE:    if (w_last) w_nxt = S_IDLE;
            default:    w_nxt = S_IDLE;
        endcase
    end

    // Counters restart at zero at every pulse boundary and outside pulses.
    always_comb begin
        w_nxt_pre  = '0;
        w_nxt_tick = '0;
        if (w_pulse && !w_last) begin
            if (w_tick_end) begin
                w_nxt_tick = r_tick + 10'd1;
            end else begin
                w_nxt_pre  = r_pre + TICK_W'(1);
                w_nxt_tick = r_tick;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_pre      <= '0;
            r_tick     <= '0;
            r_tmo      <= '0;
            r_len      <= 3'd0;
            r_nib      <= 3'd0;
            r_shift    <= 24'd0;
            r_status   <= 4'd0;
            r_crc      <= 4'd0;
            r_pause_en <= 1'b0;
            r_pause    <= 10'd0;
            r_out      <= 1'b1;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_crc_req  <= 1'b0;
            r_crc_len  <= 3'd0;
            r_crc_data <= 24'd0;
        end else begin
            r_state   <= w_nxt;
            r_pre     <= w_nxt_pre;
            r_tick    <= w_nxt_tick;
            // Output reflects the pulse position of the coming cycle.
            r_out     <= !(w_nxt_pulse && (w_nxt_tick < 10'd5));
            r_ready   <= (w_nxt == S_IDLE);
            r_done    <= w_last && (w_nxt == S_IDLE);
            r_err     <= w_tmo;
            r_crc_req <= (r_state == S_IDLE) && w_accept;
            r_tmo     <= (r_state == S_CRC_WAIT) ? r_tmo + TMO_W'(1) : '0;
            if ((r_state == S_IDLE) && w_accept) begin
                r_div      <= sent_tick_div;
                r_len      <= w_len_c;
                r_nib      <= 3'd0;
                r_shift    <= sent_frame_data;
                r_status   <= sent_status;
                r_pause_en <= sent_pause_en;
                r_pause    <= w_pause_c;
                r_crc_len  <= w_len_c;
                r_crc_data <= sent_frame_data;
            end
            if ((r_state == S_CRC_WAIT) && sent_crc_ack) begin
                r_crc <= sent_crc;
            end
            if ((r_state == S_DATA) && w_last && !w_last_nib) begin
                r_shift <= {r_shift[19:0], 4'd0};
                r_nib   <= r_nib + 3'd1;
            end
        end
    end

    assign sent_out         = r_out;
    assign sent_frame_ready = r_ready;
    assign sent_frame_done  = r_done;
    assign sent_frame_err   = r_err;
    assign sent_crc_req     = r_crc_req;
    assign sent_crc_len     = r_crc_len;
    assign sent_crc_data    = r_crc_data;

endmodule

// File: tb/tb_sent_frame_tx.sv
// Directed bench for sent_frame_tx: measures line pulse lengths per frame
// and checks the CRC handshake, timeout, clamping, back-to-back and reset.
module tb_sent_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sent_tick_div;
    logic        sent_frame_req;
    logic        sent_frame_ready;
    logic [2:0]  sent_frame_len;
    logic [23:0] sent_frame_data;
    logic [3:0]  sent_status;
    logic        sent_pause_en;
    logic [9:0]  sent_pause_ticks;
    logic        sent_crc_req;
    logic [2:0]  sent_crc_len;
    logic [23:0] sent_crc_data;
    logic        sent_crc_ack;
    logic [3:0]  sent_crc;
    logic        sent_out;
    logic        sent_frame_done;
    logic        sent_frame_err;

    sent_frame_tx #(.TICK_W(16), .CRC_TMO(255)) dut (
        .clk              (clk),
        .rst              (rst),
        .sent_tick_div    (sent_tick_div),
        .sent_frame_req   (sent_frame_req),
        .sent_frame_ready (sent_frame_ready),
        .sent_frame_len   (sent_frame_len),
        .sent_frame_data  (sent_frame_data),
        .sent_status      (sent_status),
        .sent_pause_en    (sent_pause_en),
        .sent_pause_ticks (sent_pause_ticks),
        .sent_crc_req     (sent_crc_req),
        .sent_crc_len     (sent_crc_len),
        .sent_crc_data    (sent_crc_data),
        .sent_crc_ack     (sent_crc_ack),
        .sent_crc         (sent_crc),
        .sent_out         (sent_out),
        .sent_frame_done  (sent_frame_done),
        .sent_frame_err   (sent_frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // monitor state
    int cyc = 0;
    int plen_q[$];
    int plow_q[$];
    int cur_len, cur_low;
    bit in_p = 0;
    bit prev_out = 1;
    int req_cnt = 0, done_cnt = 0, err_cnt = 0, low_cnt = 0;
    int req_cyc, done_cyc, err_cyc;
    int seen_len, seen_data;
    int done_rdy, err_rdy;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            in_p = 0;
            prev_out = 1;
        end else begin
            if (sent_crc_req) begin
                req_cnt++;
                req_cyc = cyc;
                seen_len = int'(sent_crc_len);
                seen_data = int'(sent_crc_data);
            end
            if (sent_frame_err) begin
                err_cnt++;
                err_cyc = cyc;
                err_rdy = int'(sent_frame_ready);
            end
            if (sent_frame_done) begin
                done_cnt++;
                done_cyc = cyc;
                done_rdy = int'(sent_frame_ready);
                if (in_p) begin
                    plen_q.push_back(cur_len);
                    plow_q.push_back(cur_low);
                    in_p = 0;
                end
            end
            if (!sent_out) low_cnt++;
            if (!sent_out && prev_out) begin
                if (in_p) begin
                    plen_q.push_back(cur_len);
                    plow_q.push_back(cur_low);
                end
                in_p = 1;
                cur_len = 1;
                cur_low = 1;
            end else if (in_p) begin
                cur_len++;
                if (!sent_out) cur_low++;
            end
            prev_out = sent_out;
        end
    end

    // CRC calculator stand-in
    bit ack_en = 1;
    int ack_dly = 1;
    logic [3:0] crc_val = 4'h0;

    initial begin
        sent_crc_ack = 1'b0;
        sent_crc = 4'h0;
        forever begin
            @(negedge clk);
            if (sent_crc_req && ack_en && !rst) begin
                repeat (ack_dly) @(negedge clk);
                sent_crc_ack = 1'b1;
                sent_crc = crc_val;
                @(negedge clk);
                sent_crc_ack = 1'b0;
            end
        end
    end

    int exp_len[12];

    task automatic clr_mon();
        plen_q.delete();
        plow_q.delete();
        low_cnt = 0;
    endtask

    task automatic chk_pulses(input string tag, input int n, input int low);
        chk({tag, "_npulse"}, plen_q.size(), n);
        for (int i = 0; i < n && i < plen_q.size(); i++) begin
            chk($sformatf("%s_len%0d", tag, i), plen_q[i], exp_len[i]);
            chk($sformatf("%s_low%0d", tag, i), plow_q[i], low);
        end
    endtask

    task automatic send(input int div, input int len, input int data,
                        input int st, input int pen, input int pt);
        @(negedge clk); #1;
        sent_tick_div    = 16'(div);
        sent_frame_len   = 3'(len);
        sent_frame_data  = 24'(data);
        sent_status      = 4'(st);
        sent_pause_en    = 1'(pen);
        sent_pause_ticks = 10'(pt);
        sent_frame_req   = 1'b1;
        @(negedge clk); #1;
        sent_frame_req   = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int lim);
        int n;
        int e0;
        n = 0;
        e0 = done_cnt + err_cnt;
        while (done_cnt + err_cnt == e0 && n < lim) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "_end_seen"}, (n < lim) ? 1 : 0, 1);
    endtask

    int d0, e0, r0, d1, n;

    initial begin
        rst = 1'b1;
        sent_tick_div = '0;
        sent_frame_req = 1'b0;
        sent_frame_len = '0;
        sent_frame_data = '0;
        sent_status = '0;
        sent_pause_en = 1'b0;
        sent_pause_ticks = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out", int'(sent_out), 1);
        chk("rst_ready", int'(sent_frame_ready), 1);
        chk("rst_crc_req", int'(sent_crc_req), 0);
        chk("rst_done", int'(sent_frame_done), 0);
        chk("rst_err", int'(sent_frame_err), 0);
        chk("rst_crc_len", int'(sent_crc_len), 0);
        chk("rst_crc_data", int'(sent_crc_data), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // stray ack while idle must do nothing
        #1;
        sent_crc_ack = 1'b1;
        sent_crc = 4'h7;
        @(negedge clk); #1;
        sent_crc_ack = 1'b0;
        @(negedge clk); #1;
        chk("stray_ack_ready", int'(sent_frame_ready), 1);
        chk("stray_ack_req", req_cnt, 0);

        // basic frame, tick_div 0
        clr_mon();
        crc_val = 4'h5;
        send(0, 6, 24'h123456, 0, 0, 0);
        wait_end("f1", 1000);
        chk("f1_crc_len", seen_len, 6);
        chk("f1_crc_data", seen_data, 24'h123456);
        chk("f1_req_cnt", req_cnt, 1);
        chk("f1_done_rdy", done_rdy, 1);
        exp_len = '{56, 12, 13, 14, 15, 16, 17, 18, 17, 0, 0, 0};
        chk_pulses("f1", 9, 5);

        // tick_div 2 with pause
        clr_mon();
        crc_val = 4'hA;
        send(2, 1, 24'hF00000, 3, 1, 100);
        wait_end("f2", 2000);
        chk("f2_crc_len", seen_len, 1);
        exp_len = '{168, 45, 81, 66, 300, 0, 0, 0, 0, 0, 0, 0};
        chk_pulses("f2", 5, 15);

        // CRC timeout
        clr_mon();
        ack_en = 0;
        d0 = done_cnt;
        e0 = err_cnt;
        send(0, 3, 24'h111000, 1, 0, 0);
        wait_end("tmo", 400);
        chk("tmo_err_cnt", err_cnt - e0, 1);
        chk("tmo_latency", err_cyc - req_cyc, 256);
        chk("tmo_err_rdy", err_rdy, 1);
        chk("tmo_no_done", done_cnt - d0, 0);
        chk("tmo_line_low", low_cnt, 0);
        @(negedge clk); #1;
        chk("tmo_err_pulse", int'(sent_frame_err), 0);
        ack_en = 1;

        // len 0 and short pause clamp
        clr_mon();
        crc_val = 4'h0;
        send(0, 0, 24'hA00000, 0, 1, 5);
        wait_end("len0", 1000);
        chk("len0_crc_len", seen_len, 1);
        exp_len = '{56, 12, 22, 12, 12, 0, 0, 0, 0, 0, 0, 0};
        chk_pulses("len0", 5, 5);

        // len 7 clamp
        clr_mon();
        send(0, 7, 24'h123456, 0, 0, 0);
        wait_end("len7", 1000);
        chk("len7_crc_len", seen_len, 6);
        exp_len = '{56, 12, 13, 14, 15, 16, 17, 18, 12, 0, 0, 0};
        chk_pulses("len7", 9, 5);

        // back-to-back with req held high, input change during frame
        clr_mon();
        r0 = req_cnt;
        d0 = done_cnt;
        @(negedge clk); #1;
        sent_tick_div = 16'd0;
        sent_frame_len = 3'd1;
        sent_frame_data = 24'h100000;
        sent_status = 4'd0;
        sent_pause_en = 1'b0;
        sent_frame_req = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        sent_frame_data = 24'h200000;
        n = 0;
        while (done_cnt == d0 && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        chk("b2b_first_done", (n < 500) ? 1 : 0, 1);
        d1 = done_cyc;
        n = 0;
        while (req_cnt < r0 + 2 && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        sent_frame_req = 1'b0;
        chk("b2b_accept_gap", req_cyc - d1, 1);
        chk("b2b_second_data", seen_data, 24'h200000);
        n = 0;
        while (done_cnt < d0 + 2 && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        chk("b2b_second_done", (n < 500) ? 1 : 0, 1);
        repeat (5) @(negedge clk);
        #1;
        chk("b2b_req_cnt", req_cnt - r0, 2);
        exp_len = '{56, 12, 13, 12, 56, 12, 14, 12, 0, 0, 0, 0};
        chk_pulses("b2b", 8, 5);

        // reset in the middle of DATA
        clr_mon();
        crc_val = 4'h5;
        send(0, 6, 24'h123456, 0, 0, 0);
        n = 0;
        while (plen_q.size() < 2 && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        chk("rstmid_in_data", (n < 500) ? 1 : 0, 1);
        repeat (10) @(negedge clk);
        #1;
        d0 = done_cnt;
        e0 = err_cnt;
        rst = 1'b1;
        @(negedge clk); #1;
        chk("rstmid_out", int'(sent_out), 1);
        chk("rstmid_ready", int'(sent_frame_ready), 1);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("rstmid_no_done", done_cnt - d0, 0);
        chk("rstmid_no_err", err_cnt - e0, 0);

        clr_mon();
        crc_val = 4'h1;
        send(1, 2, 24'h5A0000, 15, 0, 0);
        wait_end("post", 1000);
        exp_len = '{112, 54, 34, 44, 26, 0, 0, 0, 0, 0, 0, 0};
        chk_pulses("post", 5, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
